// File: rtl/dc_ctrl_pkg.sv
// dc_ctrl_pkg: shared constants for the DC-error window sequencer.
//   DC_ERR_W / DC_ACC_W : default error-sample and accumulator widths
//   ERR_MAX / ERR_MIN   : 1s17 saturation limits of the DC estimate
//   ST_*                : sequencer state encodings
package dc_ctrl_pkg;

    localparam int DC_ERR_W = 18;
    localparam int DC_ACC_W = 38;

    localparam logic signed [DC_ERR_W-1:0] ERR_MAX = {1'b0, {(DC_ERR_W-1){1'b1}}};
    localparam logic signed [DC_ERR_W-1:0] ERR_MIN = {1'b1, {(DC_ERR_W-1){1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

endpackage

// File: rtl/dc_round_sat.sv
// dc_round_sat: combinational window mean.
//   sum_i  : accumulator dump, signed ACC_W
//   mean_o : (sum_i + 2**(LOG2_WIN-1)) >>> LOG2_WIN, saturated to signed ERR_W
// Rounding is half toward +inf; the add is one bit wider than the sum so it
// cannot wrap.
module dc_round_sat
    import dc_ctrl_pkg::*;
#(
    parameter int LOG2_WIN = 10,
    parameter int ERR_W    = DC_ERR_W,
    parameter int ACC_W    = DC_ACC_W
) (
    input  logic signed [ACC_W-1:0] sum_i,
    output logic signed [ERR_W-1:0] mean_o
);

    localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) << (LOG2_WIN-1);
    localparam logic signed [ACC_W:0] MAX_W = {{(ACC_W-ERR_W+2){1'b0}}, {(ERR_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_W = {{(ACC_W-ERR_W+2){1'b1}}, {(ERR_W-1){1'b0}}};

    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shr;

    always_comb begin
        rnd = $signed({sum_i[ACC_W-1], sum_i}) + HALF;
        shr = rnd >>> LOG2_WIN;
        if (shr > MAX_W)
            mean_o = MAX_W[ERR_W-1:0];
        else if (shr < MIN_W)
            mean_o = MIN_W[ERR_W-1:0];
        else
            mean_o = shr[ERR_W-1:0];
    end

endmodule

// File: rtl/dc_err_ctrl.sv
// dc_err_ctrl: window sequencer for the dc_error accumulator.
//   clk, reset          : clock, synchronous active-high reset
//   start/stop          : run control pulses (stop has priority)
//   continuous          : sampled on start; back-to-back windows when 1
//   sym_en              : symbol strobe, error valid at accumulator input
//   acc_clk_en/acc_clear: accumulator controls (combinational from sym_en)
//   acc_sum             : accumulator dump
//   dc_est/dc_valid/dc_ready : rounded window mean, valid/ready handshake
//   busy                : not IDLE
//   overflow            : sticky, a result was dropped; cleared by accepted start
module dc_err_ctrl
    import dc_ctrl_pkg::*;
#(
    parameter int LOG2_WIN = 10,
    parameter int ERR_W    = DC_ERR_W,
    parameter int ACC_W    = DC_ACC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    continuous,
    input  logic                    sym_en,
    output logic                    acc_clk_en,
    output logic                    acc_clear,
    input  logic signed [ACC_W-1:0] acc_sum,
    output logic signed [ERR_W-1:0] dc_est,
    output logic                    dc_valid,
    input  logic                    dc_ready,
    output logic                    busy,
    output logic                    overflow
);

    localparam logic [LOG2_WIN:0] WIN_C = {1'b1, {LOG2_WIN{1'b0}}};
    localparam logic [LOG2_WIN:0] ONE_C = {{LOG2_WIN{1'b0}}, 1'b1};

    logic [1:0]             state_q, state_d;
    logic [LOG2_WIN:0]      cnt_q, cnt_d;
    logic                   cont_q, cont_d;
    logic                   fl_q, fl_d;     // second FLUSH cycle
    logic                   dump_q, dump_d; // acc_sum holds a real window sum this cycle
    logic                   clr, en;
    logic signed [ERR_W-1:0] est_q, mean;
    logic                   vld_q, ovf_q;
    logic                   start_ok;

    assign start_ok = (state_q == ST_IDLE) && start && !stop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cont_d  = cont_q;
        fl_d    = 1'b0;
        dump_d  = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_PRIME;
                    cont_d  = continuous;
                    cnt_d   = '0;
                end
            end
            ST_PRIME: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sym_en) begin
                    // Dump from this clear is stale and never captured.
                    clr     = 1'b1;
                    cnt_d   = ONE_C;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sym_en) begin
                    if (cnt_q == WIN_C) begin
                        // Clear both dumps the window and loads this sample
                        // as sample 1 of the next window.
                        clr    = 1'b1;
                        dump_d = 1'b1;
                        cnt_d  = ONE_C;
                        if (!cont_q)
                            state_d = ST_FLUSH;
                    end else begin
                        en    = 1'b1;
                        cnt_d = cnt_q + ONE_C;
                    end
                end
            end
            ST_FLUSH: begin
                if (stop || fl_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    fl_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    dc_round_sat #(
        .LOG2_WIN (LOG2_WIN),
        .ERR_W    (ERR_W),
        .ACC_W    (ACC_W)
    ) u_round_sat (
        .sum_i  (acc_sum),
        .mean_o (mean)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cont_q  <= 1'b0;
            fl_q    <= 1'b0;
            dump_q  <= 1'b0;
            est_q   <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            fl_q    <= fl_d;
            // An issued dump still lands after stop.
            dump_q  <= dump_d;
            if (start_ok)
                ovf_q <= 1'b0;
            if (dump_q) begin
                // Loads when the slot is free or being accepted this cycle.
                if (!vld_q || dc_ready) begin
                    est_q <= mean;
                    vld_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (vld_q && dc_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign acc_clk_en = en & ~reset;
    assign acc_clear  = clr & ~reset;
    assign dc_est     = est_q;
    assign dc_valid   = vld_q;
    assign busy       = (state_q != ST_IDLE);
    assign overflow   = ovf_q;

endmodule
